// File: rtl/emergency_request_ctrl.sv
// emergency_request_ctrl: synchronised, debounced, duration-bounded emergency level with cooldown.
// Optional EMERGENCY_COUNT_EN adds event_count, a saturating count of accepted requests.
module emergency_request_ctrl #(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int MIN_ACTIVE      = 4,
  parameter int MAX_ACTIVE      = 16,
  parameter int COOLDOWN        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_raw,
  input  logic       override_clr,
  output logic       emergency,
  output logic [1:0] state,
`ifdef EMERGENCY_COUNT_EN
  output logic [7:0] event_count,
`endif
  output logic       timeout
);
  typedef enum logic [1:0] {IDLE, DEBOUNCE, ACTIVE, COOL} state_t;
  localparam int MX = (DEBOUNCE_CYCLES > MAX_ACTIVE) ?
                      ((DEBOUNCE_CYCLES > COOLDOWN) ? DEBOUNCE_CYCLES : COOLDOWN) :
                      ((MAX_ACTIVE > COOLDOWN) ? MAX_ACTIVE : COOLDOWN);
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] DB  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] MN  = CW'(MIN_ACTIVE);
  localparam logic [CW-1:0] MXA = CW'(MAX_ACTIVE);
  localparam logic [CW-1:0] CD  = CW'(COOLDOWN);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sync_q, req_s_q, emergency_q, emergency_d, timeout_q, timeout_d;
  logic act_end;
  assign act_end = override_clr || cnt_q == MXA || (cnt_q >= MN && !req_s_q);
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + ONE;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = ONE;
        state_d = req_s_q ? DEBOUNCE : IDLE;
      end
      DEBOUNCE: begin
        state_d = !req_s_q ? IDLE : (cnt_q == DB) ? ACTIVE : DEBOUNCE;
        cnt_d   = (req_s_q && cnt_q == DB) ? ONE : cnt_q + ONE;
      end
      ACTIVE: begin
        state_d   = act_end ? COOL : ACTIVE;
        cnt_d     = act_end ? ONE : cnt_q + ONE;
        timeout_d = !override_clr && cnt_q == MXA;
      end
      COOL: state_d = (cnt_q == CD) ? IDLE : COOL;
      default: state_d = IDLE;
    endcase
    emergency_d = state_d == ACTIVE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= 1'b0;
      req_s_q     <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      emergency_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      sync_q      <= req_raw;
      req_s_q     <= sync_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      emergency_q <= emergency_d;
      timeout_q   <= timeout_d;
    end
  end
  assign emergency = emergency_q;
  assign state     = state_q;
  assign timeout   = timeout_q;
`ifdef EMERGENCY_COUNT_EN
  logic [7:0] ev_q, ev_d;
  assign ev_d = (state_q == DEBOUNCE && state_d == ACTIVE && ev_q != 8'hff) ? ev_q + 8'd1 : ev_q;
  always_ff @(posedge clk) begin
    if (rst) ev_q <= '0;
    else ev_q <= ev_d;
  end
  assign event_count = ev_q;
`endif
endmodule

// File: tb/tb_emergency_request_ctrl.sv
// tb_emergency_request_ctrl: random and directed stimulus against a timestamp-based reference model,
// expectations queued per edge and checked by an independent monitor.
module tb_emergency_request_ctrl;
  localparam int D = 3, MN = 4, MXA = 16, CD = 8;
  logic clk = 1'b0, rst = 1'b1, req_raw = 1'b0, override_clr = 1'b0;
  logic emergency, timeout;
  logic [1:0] state;
`ifdef EMERGENCY_COUNT_EN
  logic [7:0] event_count;
`endif
  always #5 clk = ~clk;
  emergency_request_ctrl dut (
    .clk(clk), .rst(rst), .req_raw(req_raw), .override_clr(override_clr),
    .emergency(emergency), .state(state),
`ifdef EMERGENCY_COUNT_EN
    .event_count(event_count),
`endif
    .timeout(timeout)
  );
  typedef struct packed {logic em; logic [1:0] st; logic to; logic [7:0] ev;} exp_t;
  exp_t q[$];
  exp_t e;
  int total = 0, bad = 0;
  int cyc = 0, m_start = 0, m_phase = 0, m_ev = 0;
  bit m_s1 = 0, m_s2 = 0, m_to = 0;
  function automatic void chk(string n, int a, int x);
    total++;
    if (a != x) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", n, $time, a, x);
    end
  endfunction
  function automatic void enter(int p);
    m_phase = p;
    m_start = cyc;
  endfunction
  // Phase time is measured as edges elapsed since the phase was entered.
  function automatic void model_edge(bit r, bit c, bit rs);
    bit rq = m_s2;
    int el;
    cyc++;
    el = cyc - m_start;
    m_to = 0;
    if (rs) begin
      m_s1 = 0; m_s2 = 0; m_ev = 0;
      enter(0);
    end else begin
      m_s2 = m_s1; m_s1 = r;
      if (m_phase == 0) begin
        if (rq) enter(1);
      end else if (m_phase == 1) begin
        if (!rq) enter(0);
        else if (el == D) begin
          enter(2);
          m_ev = (m_ev < 255) ? m_ev + 1 : 255;
        end
      end else if (m_phase == 2) begin
        if (c) enter(3);
        else if (el == MXA) begin enter(3); m_to = 1; end
        else if (el >= MN && !rq) enter(3);
      end else if (el == CD) enter(0);
    end
    q.push_back('{em: m_phase == 2, st: 2'(m_phase), to: m_to, ev: 8'(m_ev)});
  endfunction
  task automatic step(bit r, bit c, bit rs);
    @(negedge clk);
    req_raw = r; override_clr = c; rst = rs;
    model_edge(r, c, rs);
  endtask
  task automatic hold(bit r, int n);
    repeat (n) step(r, 0, 0);
  endtask
  task automatic to_active();
    int k = 0;
    while (m_phase != 2 && k < 30) begin step(1, 0, 0); k++; end
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("emergency", int'(emergency), int'(e.em));
      chk("state", int'(state), int'(e.st));
      chk("timeout", int'(timeout), int'(e.to));
`ifdef EMERGENCY_COUNT_EN
      chk("event_count", int'(event_count), int'(e.ev));
`endif
    end
  end
  initial begin
    int n;
    bit r;
    step(0, 0, 1); step(0, 0, 1);
    hold(0, 3);
    hold(1, 2); hold(0, 10);
    hold(1, 6); hold(0, 20);
    hold(1, 40); hold(0, 20);
    to_active(); step(1, 0, 0); step(1, 1, 0); hold(1, 3); hold(0, 20);
    to_active(); step(1, 0, 0); step(1, 0, 1); hold(1, 10); hold(0, 25);
    repeat (200) begin
      r = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 24);
      repeat (n) step(r, $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
    end
`ifdef EMERGENCY_COUNT_EN
    step(0, 0, 1);
    repeat (300) begin hold(1, 6); hold(0, 14); end
`endif
    @(posedge clk);
    #2;
    chk("drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
